// File: rtl/instruction_line_responder_pkg.sv
// Shared configuration, state encoding and write payload for the instruction line responder.
package instruction_line_responder_pkg;

  localparam logic [31:0] IMEM_BASE_ADDRESS = 32'h0000_0000;
  localparam int unsigned IMEM_LINE_COUNT   = 1024;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0013;

  typedef enum logic {
    IMEM_CLEAR,
    IMEM_RUN
  } ImemState_;

  // index is kept full width so the payload does not depend on LINE_COUNT
  typedef struct packed {
    logic [31:0] index;
    logic [1:0]  wordSelect;
    logic [31:0] data;
    logic [3:0]  strobe;
  } LineWrite_;

  // 33-bit window test so a window ending at 2**32 does not wrap
  function automatic logic inWindow(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned lineCount);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + (33'(lineCount) << 4);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/instruction_line_responder_if.sv
// Fetch and program-load signals between the prefetch queue/loader and the responder.
interface instruction_line_responder_if;
  logic [31:0]  alignedAddress;
  logic [127:0] instructionFetchData;
  logic         instructionFetchDataValid;
  logic         fetchFault;
  logic         loadValid;
  logic [31:0]  loadAddress;
  logic [31:0]  loadData;
  logic [3:0]   loadStrobe;
  logic         loadReady;
  logic         loadError;
  logic         initDone;

  modport master (
    output alignedAddress, loadValid, loadAddress, loadData, loadStrobe,
    input  instructionFetchData, instructionFetchDataValid, fetchFault,
           loadReady, loadError, initDone
  );

  modport slave (
    input  alignedAddress, loadValid, loadAddress, loadData, loadStrobe,
    output instructionFetchData, instructionFetchDataValid, fetchFault,
           loadReady, loadError, initDone
  );
endinterface

// File: rtl/instruction_line_bank.sv
// LINE_COUNT x 128-bit line storage: registered read, byte-enabled 32-bit write, write-first bypass.
module instruction_line_bank
  import instruction_line_responder_pkg::*;
#(
  parameter  int unsigned LINE_COUNT  = IMEM_LINE_COUNT,
  localparam int unsigned INDEX_WIDTH = $clog2(LINE_COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] readIndex,
  output logic [127:0]           readLine,
  input  logic                   writeEnable,
  input  LineWrite_              write,
  input  logic                   fillLine
);

  logic [127:0]           storage [LINE_COUNT];
  logic [INDEX_WIDTH-1:0] writeIndex;
  logic [127:0]           writeLine;
  logic [127:0]           mergedLine;
  logic [15:0]            byteEnable;
  logic                   unusedIndexBits;

  assign unusedIndexBits = ^write.index[31:INDEX_WIDTH];

  // fillLine replicates the word across the line and enables all 16 bytes
  always_comb begin
    writeIndex = write.index[INDEX_WIDTH-1:0];
    writeLine  = {4{write.data}};
    byteEnable = fillLine ? '1 : ({12'h000, write.strobe} << {write.wordSelect, 2'b00});
    mergedLine = storage[writeIndex];
    for (int unsigned b = 0; b < 16; b++) begin
      if (byteEnable[b]) mergedLine[8*b +: 8] = writeLine[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (writeEnable) storage[writeIndex] <= mergedLine;
  end

  always_ff @(posedge clock) begin
    if (reset)                                         readLine <= '0;
    else if (writeEnable && (writeIndex == readIndex)) readLine <= mergedLine;
    else                                               readLine <= storage[readIndex];
  end

endmodule

// File: rtl/instruction_line_responder.sv
// Memory-side fetch responder: streams one 128-bit line per cycle, accepts program loads, clears on reset.
module instruction_line_responder
  import instruction_line_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = IMEM_BASE_ADDRESS,
  parameter int unsigned LINE_COUNT     = IMEM_LINE_COUNT,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] FILL_WORD      = NOP_WORD
) (
  input logic clock,
  input logic reset,
  instruction_line_responder_if.slave bus
);

  localparam int unsigned            INDEX_WIDTH = $clog2(LINE_COUNT);
  localparam logic [INDEX_WIDTH-1:0] LAST_LINE   = INDEX_WIDTH'(LINE_COUNT - 1);

  ImemState_              state;
  logic [INDEX_WIDTH-1:0] clearCounter;
  logic                   validReg;
  logic                   fetchFaultReg;
  logic                   loadErrorReg;
  logic                   initDoneReg;

  logic                   fetchInRange;
  logic                   loadInRange;
  logic                   loadAccepted;
  logic [31:0]            fetchOffset;
  logic [31:0]            loadOffset;
  logic [INDEX_WIDTH-1:0] readIndex;
  LineWrite_              lineWrite;
  logic                   bankWriteEnable;
  logic                   fillLine;
  logic [127:0]           bankLine;
  logic                   unusedOffsetBits;

  assign unusedOffsetBits = ^{fetchOffset[3:0], fetchOffset[31:INDEX_WIDTH+4], loadOffset[1:0]};

  // CLEAR and program loads share the single bank write port
  always_comb begin
    fetchInRange    = inWindow(bus.alignedAddress, BASE_ADDRESS, LINE_COUNT);
    loadInRange     = inWindow(bus.loadAddress, BASE_ADDRESS, LINE_COUNT);
    fetchOffset     = bus.alignedAddress - BASE_ADDRESS;
    loadOffset      = bus.loadAddress - BASE_ADDRESS;
    readIndex       = fetchOffset[INDEX_WIDTH+3:4];
    loadAccepted    = bus.loadValid && initDoneReg;
    lineWrite       = '0;
    fillLine        = 1'b0;
    bankWriteEnable = 1'b0;
    if (state == IMEM_CLEAR) begin
      lineWrite.index  = 32'(clearCounter);
      lineWrite.data   = FILL_WORD;
      lineWrite.strobe = '1;
      fillLine         = 1'b1;
      bankWriteEnable  = !reset;
    end else begin
      lineWrite.index      = {4'h0, loadOffset[31:4]};
      lineWrite.wordSelect = loadOffset[3:2];
      lineWrite.data       = bus.loadData;
      lineWrite.strobe     = bus.loadStrobe;
      bankWriteEnable      = !reset && loadAccepted && loadInRange;
    end
  end

  instruction_line_bank #(.LINE_COUNT(LINE_COUNT)) bank (
    .clock       (clock),
    .reset       (reset),
    .readIndex   (readIndex),
    .readLine    (bankLine),
    .writeEnable (bankWriteEnable),
    .write       (lineWrite),
    .fillLine    (fillLine)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= CLEAR_ON_RESET ? IMEM_CLEAR : IMEM_RUN;
      clearCounter  <= '0;
      validReg      <= 1'b0;
      fetchFaultReg <= 1'b0;
      loadErrorReg  <= 1'b0;
      initDoneReg   <= 1'b0;
    end else begin
      validReg      <= (state == IMEM_RUN);
      fetchFaultReg <= (state == IMEM_RUN) && !fetchInRange;
      loadErrorReg  <= loadAccepted && !loadInRange;
      case (state)
        IMEM_CLEAR: begin
          clearCounter <= clearCounter + 1'b1;
          if (clearCounter == LAST_LINE) begin
            state       <= IMEM_RUN;
            initDoneReg <= 1'b1;
          end
        end
        IMEM_RUN: initDoneReg <= 1'b1;
        default:  state <= IMEM_RUN;
      endcase
    end
  end

  assign bus.instructionFetchData      = fetchFaultReg ? {4{FILL_WORD}} : bankLine;
  assign bus.instructionFetchDataValid = validReg;
  assign bus.fetchFault                = fetchFaultReg;
  assign bus.loadReady                 = initDoneReg;
  assign bus.loadError                 = loadErrorReg;
  assign bus.initDone                  = initDoneReg;

endmodule

// File: tb/tb_instruction_line_responder.sv
// Randomized bench for two responders (clearing and preserving) against a line-array reference model.
module tb_instruction_line_responder;
  import instruction_line_responder_pkg::*;

  localparam int unsigned LINES = 4;
  localparam logic [31:0] FILL  = 32'h0000_0013;
  localparam logic [31:0] BASE_OF [2] = '{32'h0000_0000, 32'h0000_1000};
  localparam bit          CLEAR_OF [2] = '{1'b1, 1'b0};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] fetchAddr [2];
  logic        loadValid [2];
  logic [31:0] loadAddr  [2];
  logic [31:0] loadData  [2];
  logic [3:0]  loadStrobe[2];
  logic        rst       [2];

  logic [127:0] obsData [2];
  logic         obsValid[2], obsFault[2], obsReady[2], obsError[2], obsInit[2];

  instruction_line_responder_if busA ();
  instruction_line_responder_if busB ();

  assign busA.alignedAddress = fetchAddr[0];
  assign busA.loadValid      = loadValid[0];
  assign busA.loadAddress    = loadAddr[0];
  assign busA.loadData       = loadData[0];
  assign busA.loadStrobe     = loadStrobe[0];
  assign busB.alignedAddress = fetchAddr[1];
  assign busB.loadValid      = loadValid[1];
  assign busB.loadAddress    = loadAddr[1];
  assign busB.loadData       = loadData[1];
  assign busB.loadStrobe     = loadStrobe[1];

  assign obsData[0]  = busA.instructionFetchData;
  assign obsValid[0] = busA.instructionFetchDataValid;
  assign obsFault[0] = busA.fetchFault;
  assign obsReady[0] = busA.loadReady;
  assign obsError[0] = busA.loadError;
  assign obsInit[0]  = busA.initDone;
  assign obsData[1]  = busB.instructionFetchData;
  assign obsValid[1] = busB.instructionFetchDataValid;
  assign obsFault[1] = busB.fetchFault;
  assign obsReady[1] = busB.loadReady;
  assign obsError[1] = busB.loadError;
  assign obsInit[1]  = busB.initDone;

  instruction_line_responder #(
    .BASE_ADDRESS(32'h0000_0000), .LINE_COUNT(LINES), .CLEAR_ON_RESET(1'b1), .FILL_WORD(FILL)
  ) dutA (.clock(clock), .reset(rst[0]), .bus(busA.slave));

  instruction_line_responder #(
    .BASE_ADDRESS(32'h0000_1000), .LINE_COUNT(LINES), .CLEAR_ON_RESET(1'b0), .FILL_WORD(FILL)
  ) dutB (.clock(clock), .reset(rst[1]), .bus(busB.slave));

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: plain line arrays plus a count of clear cycles still owed
  logic [127:0] mem [2][LINES];
  int           clearLeft [2];
  logic         expInit[2], expValid[2], expFault[2], expLoadError[2], checkData[2];
  logic [127:0] expData [2];

  function automatic bit inRange(input int d, input logic [31:0] a);
    longint x;
    longint lo;
    x  = {32'h0, a};
    lo = {32'h0, BASE_OF[d]};
    return (x >= lo) && (x < lo + 16 * LINES);
  endfunction

  function automatic int lineOf(input int d, input logic [31:0] a);
    return int'((a - BASE_OF[d]) >> 4) % LINES;
  endfunction

  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        clearLeft[d]    = CLEAR_OF[d] ? LINES : 0;
        expInit[d]      = 1'b0;
        expValid[d]     = 1'b0;
        expFault[d]     = 1'b0;
        expLoadError[d] = 1'b0;
        expData[d]      = '0;
        checkData[d]    = 1'b1;
      end else begin
        bit running;
        bit accepted;
        int ws;
        running         = (clearLeft[d] == 0);
        accepted        = loadValid[d] && expInit[d];
        expLoadError[d] = accepted && !inRange(d, loadAddr[d]);
        if (accepted && inRange(d, loadAddr[d])) begin
          ws = int'(loadAddr[d][3:2]);
          for (int b = 0; b < 4; b++)
            if (loadStrobe[d][b])
              mem[d][lineOf(d, loadAddr[d])][ws*32 + b*8 +: 8] = loadData[d][b*8 +: 8];
        end
        expValid[d] = running;
        if (running) begin
          expFault[d] = !inRange(d, fetchAddr[d]);
          expData[d]  = expFault[d] ? {4{FILL}} : mem[d][lineOf(d, fetchAddr[d])];
        end else begin
          mem[d][LINES - clearLeft[d]] = {4{FILL}};
          clearLeft[d]--;
          expFault[d] = 1'b0;
        end
        checkData[d] = (running || rst[d]) && !$isunknown(expData[d]);
        expInit[d]   = (clearLeft[d] == 0);
      end
    end
  endtask

  task automatic checkCycle();
    for (int d = 0; d < 2; d++) begin
      string nm;
      nm = (d == 0) ? "A" : "B";
      checkValue($sformatf("%s.valid", nm), obsValid[d], expValid[d]);
      checkValue($sformatf("%s.fault", nm), obsFault[d], expFault[d]);
      checkValue($sformatf("%s.initDone", nm), obsInit[d], expInit[d]);
      checkValue($sformatf("%s.loadReady", nm), obsReady[d], expInit[d]);
      checkValue($sformatf("%s.loadError", nm), obsError[d], expLoadError[d]);
      if (checkData[d]) checkValue($sformatf("%s.data", nm), obsData[d], expData[d]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkCycle();
  endtask

  task automatic waitInit(input int d, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!obsInit[d] && cycles < 50);
  endtask

  task automatic setLoad(input int d, input logic v, input logic [31:0] rel, input logic [31:0] data,
                         input logic [3:0] strobe);
    loadValid[d]  = v;
    loadAddr[d]   = BASE_OF[d] + rel;
    loadData[d]   = data;
    loadStrobe[d] = strobe;
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 2; d++) begin
        int rel;
        rel = int'($urandom_range(0, 32'h6F)) - 16;
        fetchAddr[d] = BASE_OF[d] + 32'(rel);
        rel = int'($urandom_range(0, 32'h6F)) - 16;
        setLoad(d, 1'($urandom_range(0, 1)), 32'(rel), $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) fetchAddr[d] = loadAddr[d];
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      fetchAddr[d] = BASE_OF[d];
      setLoad(d, 1'b0, 32'h0, 32'h0, 4'h0);
      rst[d] = 1'b1;
    end
    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    waitInit(0, n);
    checkValue("A.clearLength", 128'(n), 128'(LINES));
    repeat (2) step();

    // program load of line 0 while fetching it
    for (int w = 0; w < 4; w++) begin
      for (int d = 0; d < 2; d++) setLoad(d, 1'b1, 32'(4 * w), 32'h1111_1111 * 32'(w + 1), 4'hF);
      step();
    end
    for (int d = 0; d < 2; d++) setLoad(d, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    checkValue("A.loadedLine", obsData[0], 128'h44444444_33333333_22222222_11111111);
    checkValue("B.loadedLine", obsData[1], 128'h44444444_33333333_22222222_11111111);

    // write-first collision on the line being read
    for (int d = 0; d < 2; d++) setLoad(d, 1'b1, 32'h8, 32'h0000_00AB, 4'b0001);
    step();
    checkValue("A.collision", obsData[0], 128'h44444444_333333AB_22222222_11111111);
    checkValue("B.collision", obsData[1], 128'h44444444_333333AB_22222222_11111111);

    // just past the window: read faults, write is dropped
    for (int d = 0; d < 2; d++) begin
      fetchAddr[d] = BASE_OF[d] + 32'(16 * LINES);
      setLoad(d, 1'b1, 32'(16 * LINES), 32'hDEAD_BEEF, 4'hF);
    end
    step();
    checkValue("A.rangeFault", obsFault[0], 1'b1);
    checkValue("A.rangeError", obsError[0], 1'b1);
    for (int d = 0; d < 2; d++) setLoad(d, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    checkValue("A.errorPulse", obsError[0], 1'b0);

    // back-to-back redirects
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) fetchAddr[d] = BASE_OF[d] + ((k == 1) ? 32'h10 : (k == 3) ? 32'h20 : 32'h0);
      step();
    end

    randomCycles(300);

    // reset in the middle of CLEAR restarts the full sequence
    for (int d = 0; d < 2; d++) setLoad(d, 1'b0, 32'h0, 32'h0, 4'h0);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    repeat (2) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    waitInit(0, n);
    checkValue("A.clearRestart", 128'(n), 128'(LINES));

    // preserving instance keeps its contents across reset
    rst[1] = 1'b1;
    repeat (2) step();
    rst[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fetchAddr[1] = BASE_OF[1] + 32'(16 * (k % LINES));
      step();
    end

    randomCycles(200);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
